// File: rtl/h264_bs_pkg.sv
// Shared definitions for the H.264 bitstream byte buffer write side:
// buffer geometry, per-writer physical write spans, FSM state encoding
// and the layout of the CAVLC bit bus.
package h264_bs_pkg;

    localparam int BUF_DEPTH  = 128;
    localparam int SH_SPAN    = 3;
    localparam int CAVLC_SPAN = 8;
    localparam int OCC_W      = 8;

    // The CAVLC bus is 84 bits wide; the byte payload sits in [83:20].
    localparam int CAVLC_BYTES_MSB = 83;
    localparam int CAVLC_BYTES_LSB = 20;
    localparam int CAVLC_BIT_W     = CAVLC_BYTES_MSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } wr_state_e;

    // A CAVLC write never holds more than 8 bytes; larger counts are
    // treated as a full 8-byte write.
    function automatic logic [3:0] clamp_cavlc_inc(input logic [3:0] inc);
        return (inc > 4'd8) ? 4'd8 : inc;
    endfunction

endpackage

// File: rtl/bs_wr_sched_if.sv
// Requester/buffer-side bundle of the bitstream write scheduler.
// master = the writers, buffer and frame control around the scheduler;
// slave  = the scheduler itself.
interface bs_wr_sched_if;
    import h264_bs_pkg::*;

    logic                   frame_start;
    logic                   sh_req;
    logic                   sh_last;
    logic [1:0]             sh_inc;
    logic [23:0]            sh_bit;
    logic                   sh_gnt;
    logic                   cavlc_req;
    logic [3:0]             cavlc_inc;
    logic [CAVLC_BIT_W-1:0] cavlc_bit;
    logic                   cavlc_gnt;
    logic                   frame_end_req;
    logic [7:0]             rbsp_trailing;
    logic                   bs_valid;

    logic                   buf_sh_we;
    logic [1:0]             buf_sh_inc;
    logic [23:0]            buf_sh_bit;
    logic                   buf_cavlc_we;
    logic [3:0]             buf_cavlc_inc;
    logic [CAVLC_BIT_W-1:0] buf_cavlc_bit;
    logic                   buf_frame_done;
    logic [7:0]             buf_rbsp_trailing;

    logic                   frame_done_o;
    logic                   busy_o;
    logic                   err_o;

    modport master (
        output frame_start, sh_req, sh_last, sh_inc, sh_bit,
               cavlc_req, cavlc_inc, cavlc_bit, frame_end_req,
               rbsp_trailing, bs_valid,
        input  sh_gnt, cavlc_gnt,
               buf_sh_we, buf_sh_inc, buf_sh_bit,
               buf_cavlc_we, buf_cavlc_inc, buf_cavlc_bit,
               buf_frame_done, buf_rbsp_trailing,
               frame_done_o, busy_o, err_o
    );

    modport slave (
        input  frame_start, sh_req, sh_last, sh_inc, sh_bit,
               cavlc_req, cavlc_inc, cavlc_bit, frame_end_req,
               rbsp_trailing, bs_valid,
        output sh_gnt, cavlc_gnt,
               buf_sh_we, buf_sh_inc, buf_sh_bit,
               buf_cavlc_we, buf_cavlc_inc, buf_cavlc_bit,
               buf_frame_done, buf_rbsp_trailing,
               frame_done_o, busy_o, err_o
    );

endinterface

// File: rtl/bs_occ_cnt.sv
// Byte-buffer occupancy counter: adds the bytes granted this cycle and
// removes one byte per read strobe. A read strobe on an empty buffer is
// flagged and leaves the count where it is instead of wrapping.
module bs_occ_cnt
    import h264_bs_pkg::*;
#(
    parameter int W = OCC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   inc,
    input  logic         dec,
    output logic [W-1:0] occ,
    output logic         underflow
);

    logic [W-1:0] occ_q;
    logic [W-1:0] occ_d;

    // Next occupancy; the decrement is suppressed when already empty.
    always_comb begin
        underflow = dec && (occ_q == '0);
        occ_d     = occ_q + {{(W-4){1'b0}}, inc};
        if (dec && !underflow) begin
            occ_d = occ_d - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

endmodule

// File: rtl/bs_wr_sched.sv
// Write-side scheduler of the bitstream byte buffer. Grants slice-header
// and CAVLC writers onto the buffer write ports (header first), walks each
// frame through header, data, trailing-byte and drain phases, and holds
// back grants whenever a write span would overrun bytes not yet read.
module bs_wr_sched
    import h264_bs_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    bs_wr_sched_if.slave bus
);

    localparam logic [OCC_W:0] DEPTH_V    = (OCC_W+1)'(BUF_DEPTH);
    localparam logic [OCC_W:0] SH_NEED    = (OCC_W+1)'(SH_SPAN);
    localparam logic [OCC_W:0] CAVLC_NEED = (OCC_W+1)'(CAVLC_SPAN);
    localparam logic [OCC_W:0] TRAIL_NEED = (OCC_W+1)'(1);

    wr_state_e              state_q, state_d;
    logic [OCC_W-1:0]       occ;
    logic                   occ_underflow;
    logic [OCC_W:0]         free;
    logic                   in_hdr_data;
    logic                   sh_gnt, cavlc_gnt;
    logic                   sh_xfer, cavlc_xfer, trail_xfer;
    logic [3:0]             cavlc_inc_eff;
    logic [3:0]             granted_inc;
    logic                   proto_err;

    logic                   buf_sh_we_q, buf_sh_we_d;
    logic [1:0]             buf_sh_inc_q, buf_sh_inc_d;
    logic [23:0]            buf_sh_bit_q, buf_sh_bit_d;
    logic                   buf_cavlc_we_q, buf_cavlc_we_d;
    logic [3:0]             buf_cavlc_inc_q, buf_cavlc_inc_d;
    logic [CAVLC_BIT_W-1:0] buf_cavlc_bit_q, buf_cavlc_bit_d;
    logic                   buf_frame_done_q, buf_frame_done_d;
    logic [7:0]             buf_rbsp_trailing_q, buf_rbsp_trailing_d;
    logic                   err_q, err_d;

    // Space check, grants and the byte count admitted this cycle.
    always_comb begin
        free          = DEPTH_V - {1'b0, occ};
        in_hdr_data   = (state_q == ST_HDR) || (state_q == ST_DATA);
        sh_gnt        = in_hdr_data && (free >= SH_NEED);
        cavlc_gnt     = (state_q == ST_DATA) && !bus.sh_req && (free >= CAVLC_NEED);
        sh_xfer       = bus.sh_req && sh_gnt;
        cavlc_xfer    = bus.cavlc_req && cavlc_gnt;
        trail_xfer    = (state_q == ST_TRAIL) && (bus.rbsp_trailing != 8'd0)
                        && (free >= TRAIL_NEED);
        cavlc_inc_eff = clamp_cavlc_inc(bus.cavlc_inc);
        granted_inc   = 4'd0;
        if (sh_xfer) begin
            granted_inc = {2'b00, bus.sh_inc};
        end else if (cavlc_xfer) begin
            granted_inc = cavlc_inc_eff;
        end else if (trail_xfer) begin
            granted_inc = 4'd1;
        end
    end

    // Frame phase sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.frame_start) state_d = ST_HDR;
            ST_HDR:   if (sh_xfer && bus.sh_last) state_d = ST_DATA;
            ST_DATA:  if (bus.frame_end_req && !sh_xfer && !cavlc_xfer) state_d = ST_TRAIL;
            ST_TRAIL: if ((bus.rbsp_trailing == 8'd0) || trail_xfer) state_d = ST_DRAIN;
            ST_DRAIN: if ((occ == '0) && !bus.bs_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Protocol violations accumulate into a flag only reset can clear.
    always_comb begin
        proto_err = 1'b0;
        if (bus.sh_req && !in_hdr_data)                 proto_err = 1'b1;
        if (bus.cavlc_req && (state_q != ST_DATA))      proto_err = 1'b1;
        if (bus.frame_start && (state_q != ST_IDLE))    proto_err = 1'b1;
        if (bus.cavlc_req && (bus.cavlc_inc > 4'd8))    proto_err = 1'b1;
        if (occ_underflow)                              proto_err = 1'b1;
        err_d = err_q || proto_err;
    end

    // Buffer write port contents for the next cycle; data is zero when idle.
    always_comb begin
        buf_sh_we_d         = sh_xfer;
        buf_sh_inc_d        = sh_xfer ? bus.sh_inc : 2'd0;
        buf_sh_bit_d        = sh_xfer ? bus.sh_bit : 24'd0;
        buf_cavlc_we_d      = cavlc_xfer;
        buf_cavlc_inc_d     = cavlc_xfer ? cavlc_inc_eff : 4'd0;
        buf_cavlc_bit_d     = cavlc_xfer ? bus.cavlc_bit : '0;
        buf_frame_done_d    = trail_xfer;
        buf_rbsp_trailing_d = trail_xfer ? bus.rbsp_trailing : 8'd0;
    end

    // State, error flag and registered buffer write ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            err_q               <= 1'b0;
            buf_sh_we_q         <= 1'b0;
            buf_sh_inc_q        <= 2'd0;
            buf_sh_bit_q        <= 24'd0;
            buf_cavlc_we_q      <= 1'b0;
            buf_cavlc_inc_q     <= 4'd0;
            buf_cavlc_bit_q     <= '0;
            buf_frame_done_q    <= 1'b0;
            buf_rbsp_trailing_q <= 8'd0;
        end else begin
            state_q             <= state_d;
            err_q               <= err_d;
            buf_sh_we_q         <= buf_sh_we_d;
            buf_sh_inc_q        <= buf_sh_inc_d;
            buf_sh_bit_q        <= buf_sh_bit_d;
            buf_cavlc_we_q      <= buf_cavlc_we_d;
            buf_cavlc_inc_q     <= buf_cavlc_inc_d;
            buf_cavlc_bit_q     <= buf_cavlc_bit_d;
            buf_frame_done_q    <= buf_frame_done_d;
            buf_rbsp_trailing_q <= buf_rbsp_trailing_d;
        end
    end

    bs_occ_cnt #(
        .W (OCC_W)
    ) u_occ (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (granted_inc),
        .dec       (bus.bs_valid),
        .occ       (occ),
        .underflow (occ_underflow)
    );

    assign bus.sh_gnt            = sh_gnt;
    assign bus.cavlc_gnt         = cavlc_gnt;
    assign bus.buf_sh_we         = buf_sh_we_q;
    assign bus.buf_sh_inc        = buf_sh_inc_q;
    assign bus.buf_sh_bit        = buf_sh_bit_q;
    assign bus.buf_cavlc_we      = buf_cavlc_we_q;
    assign bus.buf_cavlc_inc     = buf_cavlc_inc_q;
    assign bus.buf_cavlc_bit     = buf_cavlc_bit_q;
    assign bus.buf_frame_done    = buf_frame_done_q;
    assign bus.buf_rbsp_trailing = buf_rbsp_trailing_q;
    assign bus.frame_done_o      = (state_q == ST_DONE);
    assign bus.busy_o            = (state_q != ST_IDLE);
    assign bus.err_o             = err_q;

endmodule

// File: tb/tb_bs_wr_sched.sv
// Directed bench for the bitstream write scheduler: basic frame, priority,
// backpressure, missing trailing byte, protocol errors and mid-frame reset.
module tb_bs_wr_sched;
    import h264_bs_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun  = 0;
    int   failCount = 0;

    bs_wr_sched_if bus ();

    bs_wr_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CAVLC_BIT_W-1:0] mkCavlc(input logic [63:0] b);
        logic [CAVLC_BIT_W-1:0] v;
        v = '0;
        v[CAVLC_BYTES_MSB:CAVLC_BYTES_LSB] = b;
        return v;
    endfunction

    // Drive every scheduler input, then let combinational grants settle.
    task automatic applyStimulus(input logic fs, input logic shr, input logic shl,
                                 input logic [1:0] shi, input logic [23:0] shb,
                                 input logic cr, input logic [3:0] ci, input logic [63:0] cb,
                                 input logic fe, input logic [7:0] rt, input logic bv);
        bus.frame_start   = fs;
        bus.sh_req        = shr;
        bus.sh_last       = shl;
        bus.sh_inc        = shi;
        bus.sh_bit        = shb;
        bus.cavlc_req     = cr;
        bus.cavlc_inc     = ci;
        bus.cavlc_bit     = mkCavlc(cb);
        bus.frame_end_req = fe;
        bus.rbsp_trailing = rt;
        bus.bs_valid      = bv;
        #1;
    endtask

    task automatic idleInputs(input logic bv);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, bv);
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "sh_gnt"},            bus.sh_gnt,            1'b0);
        checkOutput({pfx, "cavlc_gnt"},         bus.cavlc_gnt,         1'b0);
        checkOutput({pfx, "buf_sh_we"},         bus.buf_sh_we,         1'b0);
        checkOutput({pfx, "buf_sh_inc"},        bus.buf_sh_inc,        2'd0);
        checkOutput({pfx, "buf_sh_bit"},        bus.buf_sh_bit,        24'd0);
        checkOutput({pfx, "buf_cavlc_we"},      bus.buf_cavlc_we,      1'b0);
        checkOutput({pfx, "buf_cavlc_inc"},     bus.buf_cavlc_inc,     4'd0);
        checkOutput({pfx, "buf_cavlc_bit"},     bus.buf_cavlc_bit,     84'd0);
        checkOutput({pfx, "buf_frame_done"},    bus.buf_frame_done,    1'b0);
        checkOutput({pfx, "buf_rbsp_trailing"}, bus.buf_rbsp_trailing, 8'd0);
        checkOutput({pfx, "frame_done_o"},      bus.frame_done_o,      1'b0);
        checkOutput({pfx, "busy_o"},            bus.busy_o,            1'b0);
        checkOutput({pfx, "err_o"},             bus.err_o,             1'b0);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic pulseReset(input string pfx);
        idleInputs(1'b0);
        rst_n = 1'b0;
        #1;
        checkAllZero(pfx);
        #1;
        rst_n = 1'b1;
        clk1();
    endtask

    // Header 3,3,2 then four 8-byte CAVLC writes, trailing 0x80, full drain.
    task automatic runBasicFrame(input string pfx);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        checkOutput({pfx, "idle_sh_gnt"}, bus.sh_gnt, 1'b0);
        clk1();
        checkOutput({pfx, "start_busy"}, bus.busy_o, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 24'hAABBCC, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        checkOutput({pfx, "hdr_sh_gnt"}, bus.sh_gnt, 1'b1);
        checkOutput({pfx, "hdr_cavlc_gnt"}, bus.cavlc_gnt, 1'b0);
        checkOutput({pfx, "sh_we_latency"}, bus.buf_sh_we, 1'b0);
        clk1();
        checkOutput({pfx, "sh1_we"}, bus.buf_sh_we, 1'b1);
        checkOutput({pfx, "sh1_inc"}, bus.buf_sh_inc, 2'd3);
        checkOutput({pfx, "sh1_bit"}, bus.buf_sh_bit, 24'hAABBCC);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 24'h112233, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b1);
        clk1();
        checkOutput({pfx, "sh2_bit"}, bus.buf_sh_bit, 24'h112233);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 24'h445566, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b1);
        clk1();
        checkOutput({pfx, "sh3_inc"}, bus.buf_sh_inc, 2'd2);
        checkOutput({pfx, "sh3_bit"}, bus.buf_sh_bit, 24'h445566);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, {8{8'(i + 1)}},
                          1'b0, 8'd0, 1'b1);
            checkOutput({pfx, "data_cavlc_gnt"}, bus.cavlc_gnt, 1'b1);
            clk1();
            checkOutput({pfx, "cavlc_we"}, bus.buf_cavlc_we, 1'b1);
            checkOutput({pfx, "cavlc_inc"}, bus.buf_cavlc_inc, 4'd8);
            checkOutput({pfx, "cavlc_bit"}, bus.buf_cavlc_bit, mkCavlc({8{8'(i + 1)}}));
            if (i == 0) begin
                checkOutput({pfx, "sh_we_cleared"}, bus.buf_sh_we, 1'b0);
                checkOutput({pfx, "sh_bit_zeroed"}, bus.buf_sh_bit, 24'd0);
            end
        end

        // occ 34 -> 33, DATA -> TRAIL
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b1, 8'h80, 1'b1);
        clk1();
        checkOutput({pfx, "end_cavlc_we"}, bus.buf_cavlc_we, 1'b0);
        checkOutput({pfx, "end_no_trail_yet"}, bus.buf_frame_done, 1'b0);

        // trailing write, occ stays 33, TRAIL -> DRAIN
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'h80, 1'b1);
        checkOutput({pfx, "trail_sh_gnt"}, bus.sh_gnt, 1'b0);
        clk1();
        checkOutput({pfx, "trail_done"}, bus.buf_frame_done, 1'b1);
        checkOutput({pfx, "trail_byte"}, bus.buf_rbsp_trailing, 8'h80);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'h80, 1'b1);
        clk1();
        checkOutput({pfx, "trail_one_cycle"}, bus.buf_frame_done, 1'b0);
        checkOutput({pfx, "trail_byte_zero"}, bus.buf_rbsp_trailing, 8'd0);

        // occ 32 drained to 0, still in DRAIN
        for (int i = 0; i < 32; i++) begin
            idleInputs(1'b1);
            clk1();
        end
        checkOutput({pfx, "drain_not_done"}, bus.frame_done_o, 1'b0);
        checkOutput({pfx, "drain_busy"}, bus.busy_o, 1'b1);

        idleInputs(1'b0);
        clk1();
        checkOutput({pfx, "done_pulse"}, bus.frame_done_o, 1'b1);
        clk1();
        checkOutput({pfx, "done_one_cycle"}, bus.frame_done_o, 1'b0);
        checkOutput({pfx, "idle_busy"}, bus.busy_o, 1'b0);
        checkOutput({pfx, "clean_err"}, bus.err_o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idleInputs(1'b0);
        #1;
        checkAllZero("reset_");
        #10;
        rst_n = 1'b1;
        clk1();

        runBasicFrame("f1_");

        // Priority, backpressure and a frame without trailing byte.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 24'h0A0B0C, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        // occ 3: both request, header wins
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 24'hDDEEFF, 1'b1, 4'd8, 64'hCAFEF00D12345678,
                      1'b0, 8'd0, 1'b0);
        checkOutput("prio_sh_gnt", bus.sh_gnt, 1'b1);
        checkOutput("prio_cavlc_gnt", bus.cavlc_gnt, 1'b0);
        clk1();
        checkOutput("prio_sh_we", bus.buf_sh_we, 1'b1);
        checkOutput("prio_cavlc_we", bus.buf_cavlc_we, 1'b0);
        // occ 4: cavlc wins over frame_end_req
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'hCAFEF00D12345678,
                      1'b1, 8'd0, 1'b0);
        checkOutput("prio_cavlc_next", bus.cavlc_gnt, 1'b1);
        clk1();
        checkOutput("prio_cavlc_we2", bus.buf_cavlc_we, 1'b1);
        // occ 12 -> 124, still DATA
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h1, 1'b0, 8'd0, 1'b0);
            checkOutput("bp_ramp_gnt", bus.cavlc_gnt, 1'b1);
            clk1();
        end
        // occ 124,123,122,121: too full for 8 bytes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h2, 1'b0, 8'd0, 1'b1);
            checkOutput("bp_hold_gnt", bus.cavlc_gnt, 1'b0);
            if (i == 0) begin
                checkOutput("bp_sh_free4", bus.sh_gnt, 1'b1);
            end
            clk1();
            checkOutput("bp_hold_we", bus.buf_cavlc_we, 1'b0);
        end
        // occ 120: grant returns, occ -> 127
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h3, 1'b0, 8'd0, 1'b1);
        checkOutput("bp_resume_gnt", bus.cavlc_gnt, 1'b1);
        clk1();
        checkOutput("bp_resume_we", bus.buf_cavlc_we, 1'b1);
        // occ 127,126 then 125 (free 3)
        idleInputs(1'b1);
        checkOutput("full_sh_gnt", bus.sh_gnt, 1'b0);
        checkOutput("full_cavlc_gnt", bus.cavlc_gnt, 1'b0);
        clk1();
        idleInputs(1'b1);
        checkOutput("free2_sh_gnt", bus.sh_gnt, 1'b0);
        clk1();
        idleInputs(1'b1);
        checkOutput("free3_sh_gnt", bus.sh_gnt, 1'b1);
        clk1();
        // occ 124 -> 123, TRAIL; then 122, DRAIN without trailing write
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b1, 8'd0, 1'b1);
        clk1();
        idleInputs(1'b1);
        checkOutput("notrail_sh_gnt", bus.sh_gnt, 1'b0);
        clk1();
        checkOutput("notrail_no_pulse", bus.buf_frame_done, 1'b0);
        for (int i = 0; i < 122; i++) begin
            idleInputs(1'b1);
            clk1();
            if (i == 0) begin
                checkOutput("notrail_no_pulse2", bus.buf_frame_done, 1'b0);
            end
        end
        checkOutput("notrail_not_done", bus.frame_done_o, 1'b0);
        idleInputs(1'b0);
        clk1();
        checkOutput("notrail_done", bus.frame_done_o, 1'b1);
        clk1();
        checkOutput("notrail_err", bus.err_o, 1'b0);

        // cavlc_req during header: error, no grant, header phase kept.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h4, 1'b0, 8'd0, 1'b0);
        checkOutput("hdr_err_cavlc_gnt", bus.cavlc_gnt, 1'b0);
        clk1();
        checkOutput("hdr_err_set", bus.err_o, 1'b1);
        checkOutput("hdr_err_no_we", bus.buf_cavlc_we, 1'b0);
        idleInputs(1'b0);
        checkOutput("hdr_err_still_hdr", bus.sh_gnt, 1'b1);
        clk1();
        checkOutput("hdr_err_sticky", bus.err_o, 1'b1);
        // build occ 20 in DATA: 3 + 8 + 8 + 1
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 24'h1, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h5, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h6, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 24'h7, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        checkOutput("pre_rst_sh_we", bus.buf_sh_we, 1'b1);
        pulseReset("midrst_");

        // Fresh frame after reset must see an empty buffer.
        runBasicFrame("f4_");

        // frame_start while in DATA is flagged and ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 24'h8, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b1);
        clk1();
        checkOutput("fs_err_set", bus.err_o, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd8, 64'h9, 1'b0, 8'd0, 1'b0);
        checkOutput("fs_err_still_data", bus.cavlc_gnt, 1'b1);
        clk1();
        pulseReset("rst2_");

        // Read strobe on an empty buffer.
        idleInputs(1'b1);
        clk1();
        checkOutput("underflow_err", bus.err_o, 1'b1);
        pulseReset("rst3_");

        // Header request while idle.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 24'h1, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("idle_sh_req_gnt", bus.sh_gnt, 1'b0);
        clk1();
        checkOutput("idle_sh_req_err", bus.err_o, 1'b1);
        checkOutput("idle_sh_req_we", bus.buf_sh_we, 1'b0);
        pulseReset("rst4_");

        // Oversized CAVLC count: flagged, written as 8 bytes.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 24'h1, 1'b0, 4'd0, 64'd0, 1'b0, 8'd0, 1'b0);
        clk1();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1, 4'd12, 64'hA, 1'b0, 8'd0, 1'b0);
        checkOutput("big_inc_gnt", bus.cavlc_gnt, 1'b1);
        clk1();
        checkOutput("big_inc_clamped", bus.buf_cavlc_inc, 4'd8);
        checkOutput("big_inc_err", bus.err_o, 1'b1);
        pulseReset("rst5_");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
